// File: rtl/chrono_pkg.sv
// rtl/chrono_pkg.sv - shared states, digit limits and BCD helper for the chronometer
package chrono_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t TENTHS_MAX   = 4'd9;
    localparam digit_t SEC_ONES_MAX = 4'd9;
    localparam digit_t SEC_TENS_MAX = 4'd5;
    localparam digit_t MIN_ONES_MAX = 4'd9;
    localparam digit_t MIN_TENS_MAX = 4'd5;

    typedef struct packed {
        digit_t min_tens;
        digit_t min_ones;
        digit_t sec_tens;
        digit_t sec_ones;
        digit_t tenths;
    } count_t;

    // 59:59.9 packed as BCD nibbles, most significant digit first
    localparam count_t TERMINAL = 20'h59599;

    // Value a single BCD digit takes after an edge with the given enable
    function automatic digit_t bcd_step(input digit_t value, input logic en, input digit_t max_value);
        if (!en)
            return value;
        return (value == max_value) ? '0 : value + 4'd1;
    endfunction

endpackage

// File: rtl/chrono_if.sv
// rtl/chrono_if.sv - control pulses in, BCD digits and status out
interface chrono_if;
    import chrono_pkg::*;

    logic   tick;
    logic   start_stop;
    logic   lap;
    logic   clear;
    digit_t tenths;
    digit_t sec_ones;
    digit_t sec_tens;
    digit_t min_ones;
    digit_t min_tens;
    logic   running;
    logic   lap_active;
    logic   rollover;

    modport master (
        output tick, start_stop, lap, clear,
        input  tenths, sec_ones, sec_tens, min_ones, min_tens,
        input  running, lap_active, rollover
    );

    modport slave (
        input  tick, start_stop, lap, clear,
        output tenths, sec_ones, sec_tens, min_ones, min_tens,
        output running, lap_active, rollover
    );

endinterface

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one BCD digit of the ripple-enable chain
module bcd_digit_counter
    import chrono_pkg::*;
#(
    parameter digit_t MAX = 4'd9
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   clr,
    output digit_t value,
    output logic   carry
);

    assign carry = en && (value == MAX);

    // Digit register: clear wins, otherwise advance and wrap past MAX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            value <= '0;
        else if (clr)
            value <= '0;
        else
            value <= bcd_step(value, en, MAX);
    end

endmodule

// File: rtl/chrono_core.sv
// rtl/chrono_core.sv - start/stop/lap/clear control and MM:SS.t time base
module chrono_core
    import chrono_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input logic     clk,
    input logic     rst,
    chrono_if.slave bus
);

    state_t state;
    state_t state_next;
    count_t live;
    count_t live_next;
    count_t snap;
    count_t snap_next;
    count_t disp;
    count_t disp_next;

    digit_t tenths_q;
    digit_t sec_ones_q;
    digit_t sec_tens_q;
    digit_t min_ones_q;
    digit_t min_tens_q;

    logic c_tenths;
    logic c_sec_ones;
    logic c_sec_tens;
    logic c_min_ones;
    logic c_min_tens;

    logic saturated;
    logic running_q;
    logic lap_active_q;
    logic rollover_q;
    logic tick_ok;
    logic at_terminal;
    logic inc_en;
    logic roll_evt;

    assign live        = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q, tenths_q};
    assign at_terminal = (live == TERMINAL);

    // A tick counts only while running; clear on the same edge discards it
    assign tick_ok  = bus.tick && !bus.clear && (state == RUN || state == LAP);
    // In saturating mode the chain is frozen once 59:59.9 is reached
    assign inc_en   = tick_ok && (WRAP || !at_terminal);
    // Wrapping mode: carry out of the top digit; saturating: first terminal tick only
    assign roll_evt = WRAP ? c_min_tens : (tick_ok && at_terminal && !saturated);

    bcd_digit_counter #(.MAX(TENTHS_MAX)) u_tenths (
        .clk(clk), .rst(rst), .en(inc_en), .clr(bus.clear),
        .value(tenths_q), .carry(c_tenths)
    );

    bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .en(c_tenths), .clr(bus.clear),
        .value(sec_ones_q), .carry(c_sec_ones)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .en(c_sec_ones), .clr(bus.clear),
        .value(sec_tens_q), .carry(c_sec_tens)
    );

    bcd_digit_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .en(c_sec_tens), .clr(bus.clear),
        .value(min_ones_q), .carry(c_min_ones)
    );

    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .en(c_min_ones), .clr(bus.clear),
        .value(min_tens_q), .carry(c_min_tens)
    );

    // Post-edge live count, needed so a lap snapshot includes a same-edge tick
    always_comb begin
        live_next = live;
        if (bus.clear) begin
            live_next = '0;
        end else begin
            live_next.tenths   = bcd_step(live.tenths,   inc_en,     TENTHS_MAX);
            live_next.sec_ones = bcd_step(live.sec_ones, c_tenths,   SEC_ONES_MAX);
            live_next.sec_tens = bcd_step(live.sec_tens, c_sec_ones, SEC_TENS_MAX);
            live_next.min_ones = bcd_step(live.min_ones, c_sec_tens, MIN_ONES_MAX);
            live_next.min_tens = bcd_step(live.min_tens, c_sec_tens && c_min_ones, MIN_TENS_MAX);
        end
    end

    // Control FSM next state: clear > start_stop > lap, saturation forces a pause
    always_comb begin
        state_next = state;
        if (bus.clear) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (bus.start_stop) state_next = RUN;
                RUN:     if (bus.start_stop) state_next = PAUSE;
                         else if (bus.lap)   state_next = LAP;
                PAUSE:   if (bus.start_stop) state_next = RUN;
                LAP:     if (bus.start_stop) state_next = PAUSE;
                         else if (bus.lap)   state_next = RUN;
                default: state_next = IDLE;
            endcase
            if (roll_evt && !WRAP)
                state_next = PAUSE;
        end
    end

    // Snapshot capture on entering LAP, and the display source for the next cycle
    always_comb begin
        snap_next = snap;
        if (bus.clear)
            snap_next = '0;
        else if (state == RUN && !bus.start_stop && bus.lap)
            snap_next = live_next;
        disp_next = (state_next == LAP) ? snap_next : live_next;
    end

    // Control FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Snapshot, saturation flag and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap         <= '0;
            saturated    <= 1'b0;
            disp         <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            rollover_q   <= 1'b0;
        end else begin
            snap         <= snap_next;
            disp         <= disp_next;
            running_q    <= (state_next == RUN) || (state_next == LAP);
            lap_active_q <= (state_next == LAP);
            rollover_q   <= roll_evt;
            if (bus.clear)
                saturated <= 1'b0;
            else if (roll_evt && !WRAP)
                saturated <= 1'b1;
        end
    end

    assign bus.tenths     = disp.tenths;
    assign bus.sec_ones   = disp.sec_ones;
    assign bus.sec_tens   = disp.sec_tens;
    assign bus.min_ones   = disp.min_ones;
    assign bus.min_tens   = disp.min_tens;
    assign bus.running    = running_q;
    assign bus.lap_active = lap_active_q;
    assign bus.rollover   = rollover_q;

endmodule
